ifu: RTL and testbench

Instruction fetch unit: owns the architectural PC, fetches one 32-bit instruction at a time from instruction memory over a request/grant/response interface, and presents `{inst, pc}` to the decode stage under a valid/ready handshake. It is the producer feeding the decoder. It also accepts branch/jump redirects from execute and squashes wrong-path fetches, one outstanding request at most.

---
 rtl/ifu.sv | 104 ++++++++++
 tb/tb_ifu.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, fetches one instruction at a time
// and hands {inst, pc} to decode over valid/ready.
module ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o_ifu,
  output logic [63:0] imem_addr_o_ifu,
  input  logic        imem_gnt_i_ifu,
  input  logic        imem_rvalid_i_ifu,
  input  logic [31:0] imem_rdata_i_ifu,
  input  logic        redirect_i_ifu,
  input  logic [63:0] redirect_pc_i_ifu,
  output logic        valid_o_ifu,
  input  logic        ready_i_ifu,
  output logic [31:0] inst_o_ifu,
  output logic [63:0] pc_o_ifu
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_OUT,
    S_DRAIN
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [63:0] r_pc;
  logic [63:0] w_pc_nxt;
  logic [31:0] r_inst_q;
  logic [63:0] r_pc_q;
  logic        w_capture;
  logic [63:0] w_redir_pc;
  logic        w_unused;

  assign w_redir_pc = {redirect_pc_i_ifu[63:2], 2'b00};
  assign w_unused   = ^redirect_pc_i_ifu[1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_capture   = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        if (redirect_i_ifu) begin
          // a grant in this cycle belongs to the stale address
          w_state_nxt = imem_gnt_i_ifu ? S_DRAIN : S_FETCH;
        end else if (imem_gnt_i_ifu) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_i_ifu) begin
          w_state_nxt = imem_rvalid_i_ifu ? S_FETCH : S_DRAIN;
        end else if (imem_rvalid_i_ifu) begin
          w_capture   = 1'b1;
          w_state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        if (redirect_i_ifu) begin
          w_state_nxt = S_FETCH;
        end else if (ready_i_ifu) begin
          w_pc_nxt    = r_pc + 64'd4;
          w_state_nxt = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (imem_rvalid_i_ifu) begin
          w_state_nxt = S_FETCH;
        end
      end
      default: w_state_nxt = S_FETCH;
    endcase
    if (redirect_i_ifu) begin
      w_pc_nxt = w_redir_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_FETCH;
      r_pc     <= RESET_PC;
      r_inst_q <= 32'd0;
      r_pc_q   <= 64'd0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_capture) begin
        r_inst_q <= imem_rdata_i_ifu;
        r_pc_q   <= r_pc;
      end
    end
  end

  assign imem_req_o_ifu  = (r_state == S_FETCH) && !rst;
  assign imem_addr_o_ifu = r_pc;
  assign valid_o_ifu     = (r_state == S_OUT) && !rst;
  assign inst_o_ifu      = r_inst_q;
  assign pc_o_ifu        = r_pc_q;

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: randomized memory/redirect/ready traffic
// checked against a transaction-level model of fetch and delivery.
module tb_ifu;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clk;
  logic        rst;
  logic        req;
  logic [63:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        valid;
  logic        ready;
  logic [31:0] inst;
  logic [63:0] pc;

  ifu dut (
    .clk               (clk),
    .rst               (rst),
    .imem_req_o_ifu    (req),
    .imem_addr_o_ifu   (addr),
    .imem_gnt_i_ifu    (gnt),
    .imem_rvalid_i_ifu (rvalid),
    .imem_rdata_i_ifu  (rdata),
    .redirect_i_ifu    (redirect),
    .redirect_pc_i_ifu (redirect_pc),
    .valid_o_ifu       (valid),
    .ready_i_ifu       (ready),
    .inst_o_ifu        (inst),
    .pc_o_ifu          (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // reference model: architectural fetch PC, held instruction,
  // outstanding request status (0 none, 1 live, 2 killed)
  logic [63:0] m_pc;
  bit          m_have;
  logic [31:0] m_inst;
  logic [63:0] m_ipc;
  int          m_os;

  // memory model
  bit          mem_pend;
  logic [63:0] mem_addr;
  int          mem_cnt;
  int          p_gnt;
  int          lat_lo;
  int          lat_hi;
  int          p_spur;

  logic [63:0] dlv[$];
  int          dlv_cyc[$];
  logic [63:0] gnt_log[$];
  int          cyc = 0;

  logic        obs_req;
  logic [63:0] obs_addr;
  logic        obs_valid;
  logic [31:0] obs_inst;
  logic [63:0] obs_pc;

  function automatic logic [31:0] fdata(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h9E37_79B9;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc   = RST_PC;
    m_have = 1'b0;
    m_inst = 32'd0;
    m_ipc  = 64'd0;
    m_os   = 0;
  endtask

  task automatic cycle(input bit rd, input logic [63:0] rpc,
                       input bit rdy, input bit rs);
    bit          g;
    bit          rv;
    logic [31:0] rdat;
    logic [63:0] gaddr;
    @(negedge clk);
    rst         = rs;
    redirect    = rd;
    redirect_pc = rpc;
    ready       = rdy;
    rv   = !rs && mem_pend && (mem_cnt == 0);
    rdat = rv ? fdata(mem_addr) : $urandom;
    if (!rs && !mem_pend && ($urandom_range(99) < p_spur)) rv = 1'b1;
    rvalid = rv;
    rdata  = rdat;
    #1;
    g   = req && !mem_pend && ($urandom_range(99) < p_gnt);
    gnt = g;
    gaddr = addr;
    #1;
    obs_req   = req;
    obs_addr  = addr;
    obs_valid = valid;
    obs_inst  = inst;
    obs_pc    = pc;
    chk("req", {63'd0, req}, {63'd0, !rs && !m_have && m_os == 0});
    chk("addr", addr, m_pc);
    chk("valid", {63'd0, valid}, {63'd0, !rs && m_have});
    chk("inst", {32'd0, inst}, {32'd0, m_inst});
    chk("pc", pc, m_ipc);
    if (valid) chk("inst_of_pc", {32'd0, inst}, {32'd0, fdata(pc)});
    if (valid && rdy && !rd) begin
      dlv.push_back(pc);
      dlv_cyc.push_back(cyc);
    end
    if (g) gnt_log.push_back(gaddr);
    @(posedge clk);
    cyc++;
    if (rs) mem_pend = 1'b0;
    else if (g) begin
      mem_pend = 1'b1;
      mem_addr = gaddr;
      mem_cnt  = $urandom_range(lat_hi, lat_lo) - 1;
    end else if (mem_pend && rv) mem_pend = 1'b0;
    else if (mem_pend) mem_cnt--;
    if (rs) model_reset();
    else begin
      if (m_have) begin
        if (rd || rdy) begin
          m_have = 1'b0;
          if (!rd) m_pc = m_pc + 64'd4;
        end
      end else if (m_os == 0) begin
        if (g) m_os = rd ? 2 : 1;
      end else if (m_os == 1) begin
        if (rv) begin
          m_os = 0;
          if (!rd) begin
            m_have = 1'b1;
            m_inst = rdat;
            m_ipc  = m_pc;
          end
        end else if (rd) m_os = 2;
      end else begin
        if (rv) m_os = 0;
      end
      if (rd) m_pc = {rpc[63:2], 2'b00};
    end
  endtask

  task automatic run_until_deliver(input string tag, input int budget);
    int n0;
    n0 = dlv.size();
    for (int i = 0; i < budget; i++) begin
      cycle(1'b0, 64'd0, 1'b1, 1'b0);
      if (dlv.size() > n0) return;
    end
    chk({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic run_until_grant(input string tag, input int budget);
    int n0;
    n0 = gnt_log.size();
    for (int i = 0; i < budget; i++) begin
      cycle(1'b0, 64'd0, 1'b1, 1'b0);
      if (gnt_log.size() > n0) return;
    end
    chk({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    int          n0;
    bit          rd;
    logic [63:0] rpc;
    rst = 1'b1;
    gnt = 1'b0;
    rvalid = 1'b0;
    rdata = 32'd0;
    redirect = 1'b0;
    redirect_pc = 64'd0;
    ready = 1'b0;
    model_reset();
    mem_pend = 1'b0;
    mem_addr = 64'd0;
    mem_cnt = 0;
    p_gnt = 100;
    lat_lo = 1;
    lat_hi = 1;
    p_spur = 0;
    @(posedge clk);
    @(posedge clk);

    // reset state
    cycle(1'b0, 64'd0, 1'b1, 1'b1);
    chk("rst_req", {63'd0, obs_req}, 64'd0);
    chk("rst_valid", {63'd0, obs_valid}, 64'd0);
    chk("rst_pc", obs_pc, 64'd0);
    chk("rst_addr", obs_addr, RST_PC);

    // sequential fetch, 1-cycle memory, decode always ready
    cycle(1'b0, 64'd0, 1'b1, 1'b0);
    chk("first_req", {63'd0, obs_req}, 64'd1);
    chk("first_addr", obs_addr, RST_PC);
    for (int i = 0; i < 8; i++) cycle(1'b0, 64'd0, 1'b1, 1'b0);
    chk("seq_n", dlv.size(), 64'd3);
    if (dlv.size() >= 3) begin
      chk("seq_pc0", dlv[0], 64'h8000_0000);
      chk("seq_pc1", dlv[1], 64'h8000_0004);
      chk("seq_pc2", dlv[2], 64'h8000_0008);
      chk("seq_gap", 64'(dlv_cyc[1] - dlv_cyc[0]), 64'd3);
      chk("seq_gap2", 64'(dlv_cyc[2] - dlv_cyc[1]), 64'd3);
    end

    // backpressure: 5 cycles of ready=0 while holding
    for (int i = 0; i < 7; i++) cycle(1'b0, 64'd0, 1'b0, 1'b0);
    chk("bp_valid", {63'd0, obs_valid}, 64'd1);
    chk("bp_pc", obs_pc, 64'h8000_000C);
    chk("bp_req", {63'd0, obs_req}, 64'd0);
    chk("bp_addr", obs_addr, 64'h8000_000C);
    cycle(1'b0, 64'd0, 1'b1, 1'b0);
    chk("bp_accept", dlv[$], 64'h8000_000C);

    // redirect while waiting for a slow response
    lat_lo = 3;
    lat_hi = 3;
    cycle(1'b0, 64'd0, 1'b1, 1'b0);
    chk("wait_gnt", gnt_log[$], 64'h8000_0010);
    cycle(1'b1, 64'h8000_0100, 1'b1, 1'b0);
    lat_lo = 1;
    lat_hi = 1;
    run_until_deliver("wait_redir", 30);
    chk("wait_redir_pc", dlv[$], 64'h8000_0100);
    chk("wait_redir_addr", gnt_log[$], 64'h8000_0100);

    // redirect coincident with a grant
    cycle(1'b1, 64'h8000_0200, 1'b1, 1'b0);
    chk("fetch_stale_gnt", gnt_log[$], 64'h8000_0104);
    run_until_deliver("fetch_redir", 30);
    chk("fetch_redir_pc", dlv[$], 64'h8000_0200);

    // redirect coincident with handshake, unaligned target
    for (int i = 0; i < 10 && !m_have; i++) cycle(1'b0, 64'd0, 1'b0, 1'b0);
    chk("out_reached", {63'd0, m_have}, 64'd1);
    n0 = dlv.size();
    cycle(1'b1, 64'h8000_0302, 1'b1, 1'b0);
    chk("out_squash", 64'(dlv.size()), 64'(n0));
    run_until_deliver("out_redir", 30);
    chk("out_redir_pc", dlv[$], 64'h8000_0300);
    chk("unalign_addr", gnt_log[$], 64'h8000_0300);

    // PC wraps at the top of the address space
    cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0);
    run_until_deliver("wrap", 30);
    chk("wrap_pc", dlv[$], 64'hFFFF_FFFF_FFFF_FFFC);
    run_until_grant("wrap_next", 30);
    chk("wrap_addr", gnt_log[$], 64'd0);

    // reset with a request in flight
    lat_lo = 4;
    lat_hi = 4;
    for (int i = 0; i < 10 && m_os != 1; i++) begin
      cycle(1'b0, 64'd0, 1'b1, 1'b0);
    end
    chk("inflight", 64'(m_os), 64'd1);
    cycle(1'b0, 64'd0, 1'b1, 1'b1);
    chk("rw_req", {63'd0, obs_req}, 64'd0);
    chk("rw_valid", {63'd0, obs_valid}, 64'd0);
    cycle(1'b0, 64'd0, 1'b1, 1'b1);
    chk("rw_pc", obs_pc, 64'd0);
    chk("rw_inst", {32'd0, obs_inst}, 64'd0);
    cycle(1'b0, 64'd0, 1'b1, 1'b0);
    chk("rw_restart_req", {63'd0, obs_req}, 64'd1);
    chk("rw_restart_addr", obs_addr, RST_PC);

    // random traffic
    p_gnt = 60;
    lat_lo = 1;
    lat_hi = 4;
    p_spur = 10;
    for (int i = 0; i < 3000; i++) begin
      rd = ($urandom_range(99) < 8);
      case ($urandom_range(2))
        0: rpc = {$urandom, $urandom};
        1: rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
        default: rpc = 64'h8000_0000 + 64'($urandom_range(4095));
      endcase
      cycle(rd, rpc, $urandom_range(99) < 70, $urandom_range(199) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
